// File: rtl/l1_conv_pkg.sv
// Shared definitions for the layer-1 convolution output path.
//   WIN_NUM / LINE_NUM : conv windows per line, lines per frame (both even)
//   OUT_W              : output word width
//   Q_SAT              : largest value a requantised output word may take
//   state_t            : output controller frame state
package l1_conv_pkg;

    localparam int WIN_NUM  = 24;
    localparam int LINE_NUM = 50;
    localparam int OUT_W    = 8;
    localparam int ACC_W    = 20;
    localparam int SHIFT    = 6;
    localparam int PIPE_LAT = 2;

    // Largest positive value of a signed OUT_W container.
    localparam logic [OUT_W-1:0] Q_SAT = {1'b0, {(OUT_W-1){1'b1}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/l1_relu_quant.sv
// Combinational ReLU + arithmetic right shift + saturation.
//   r_i : signed MAC result (ACC_W bits)
//   q_o : non-negative requantised value in an OUT_W container,
//         0 for negative inputs, clamped to 2^(OUT_W-1)-1.
module l1_relu_quant #(
    parameter int ACC_W = 20,
    parameter int OUT_W = 8,
    parameter int SHIFT = 6
) (
    input  logic signed [ACC_W-1:0] r_i,
    output logic        [OUT_W-1:0] q_o
);

    localparam logic signed [ACC_W-1:0] SAT_W = ACC_W'(2**(OUT_W-1) - 1);

    logic signed [ACC_W-1:0] shifted;

    always_comb begin
        shifted = r_i >>> SHIFT;
        q_o     = '0;
        if (r_i[ACC_W-1]) begin
            q_o = '0;
        end else if (shifted > SAT_W) begin
            q_o = SAT_W[OUT_W-1:0];
        end else begin
            q_o = shifted[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/l1_conv_out_ctrl.sv
// Layer-1 convolution output stage: ReLU, requantisation, 2x2 max-pooling
// and sequential write of pooled words into the layer-1 output RAM.
//   clk, rstn     : clock, asynchronous active-low reset
//   vbit_i        : work-active from the input controller
//   ConvWinCnt_i  : window index of the sample presented this cycle
//   ConvResult_i  : MAC result, valid PIPE_LAT cycles after its index
//   OutRamWe_o    : output RAM write strobe
//   OutRamAddr_o  : output RAM address (0 .. pooled words - 1)
//   OutRamData_o  : pooled result
//   Done_o        : one-cycle pulse the cycle after the final write
//   Busy_o        : frame in progress
module l1_conv_out_ctrl
    import l1_conv_pkg::*;
#(
    parameter int ACC_W    = l1_conv_pkg::ACC_W,
    parameter int OUT_W    = l1_conv_pkg::OUT_W,
    parameter int SHIFT    = l1_conv_pkg::SHIFT,
    parameter int PIPE_LAT = l1_conv_pkg::PIPE_LAT,
    parameter int WIN_NUM  = l1_conv_pkg::WIN_NUM,
    parameter int LINE_NUM = l1_conv_pkg::LINE_NUM
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    vbit_i,
    input  logic [4:0]              ConvWinCnt_i,
    input  logic signed [ACC_W-1:0] ConvResult_i,
    output logic                    OutRamWe_o,
    output logic [8:0]              OutRamAddr_o,
    output logic [OUT_W-1:0]        OutRamData_o,
    output logic                    Done_o,
    output logic                    Busy_o
);

    localparam int HALF_WIN = WIN_NUM / 2;
    localparam int N_OUT    = (LINE_NUM / 2) * HALF_WIN;
    localparam int LINE_W   = $clog2(LINE_NUM);

    localparam logic [4:0]        COL_LAST  = 5'(WIN_NUM - 1);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(LINE_NUM - 1);
    localparam logic [8:0]        ADDR_LAST = 9'(N_OUT - 1);

    // ------------------------------------------------------------------
    // Delay line: aligns valid bit and window index with the MAC result.
    // ------------------------------------------------------------------
    logic       vld_sr [PIPE_LAT];
    logic [4:0] col_sr [PIPE_LAT];

    genvar gi;
    generate
        for (gi = 0; gi < PIPE_LAT; gi++) begin : g_dly
            if (gi == 0) begin : g_head
                always_ff @(posedge clk or negedge rstn) begin
                    if (!rstn) begin
                        vld_sr[gi] <= 1'b0;
                        col_sr[gi] <= '0;
                    end else begin
                        vld_sr[gi] <= vbit_i;
                        col_sr[gi] <= ConvWinCnt_i;
                    end
                end
            end else begin : g_tail
                always_ff @(posedge clk or negedge rstn) begin
                    if (!rstn) begin
                        vld_sr[gi] <= 1'b0;
                        col_sr[gi] <= '0;
                    end else begin
                        vld_sr[gi] <= vld_sr[gi-1];
                        col_sr[gi] <= col_sr[gi-1];
                    end
                end
            end
        end
    endgenerate

    logic       vld_d;
    logic [4:0] col_d;
    logic [3:0] col_idx;

    assign vld_d   = vld_sr[PIPE_LAT-1];
    assign col_d   = col_sr[PIPE_LAT-1];
    assign col_idx = col_d[4:1];

    // ------------------------------------------------------------------
    // Quantise and pool
    // ------------------------------------------------------------------
    logic [OUT_W-1:0] q;

    l1_relu_quant #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_relu_quant (
        .r_i (ConvResult_i),
        .q_o (q)
    );

    state_t            state_reg, state_next;
    logic [LINE_W-1:0] line_cnt_reg;
    logic [OUT_W-1:0]  hreg_reg;
    logic [8:0]        wr_addr_reg;
    logic [OUT_W-1:0]  linebuf [HALF_WIN];

    logic [OUT_W-1:0] h_max;
    logic [OUT_W-1:0] lb_rd;
    logic [OUT_W-1:0] p_max;
    logic             issue_wr;
    logic             lb_wr;
    logic             final_wr;
    logic             start_frame;
    logic             abort;

    always_comb begin
        h_max    = (hreg_reg > q) ? hreg_reg : q;
        lb_rd    = linebuf[col_idx];
        p_max    = (lb_rd > h_max) ? lb_rd : h_max;
        // Odd column closes a horizontal pair; line parity picks whether
        // the pair is parked in the line buffer or combined with it.
        issue_wr = vld_d & col_d[0] & line_cnt_reg[0];
        lb_wr    = vld_d & col_d[0] & ~line_cnt_reg[0];
        final_wr = OutRamWe_o && (OutRamAddr_o == ADDR_LAST);
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        start_frame = 1'b0;
        abort       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (vld_d && (line_cnt_reg == '0)) begin
                    state_next  = ST_RUN;
                    start_frame = 1'b1;
                end
            end
            ST_RUN: begin
                // Completion wins over abort: the last write lands while the
                // upstream valid is already low after the frame.
                if (final_wr) begin
                    state_next = ST_DONE;
                end else if (!vld_d && ((line_cnt_reg != '0) || (col_d != '0))) begin
                    state_next = ST_IDLE;
                    abort      = 1'b1;
                end
            end
            ST_DONE: begin
                if (vld_d && (line_cnt_reg == '0)) begin
                    state_next  = ST_RUN;
                    start_frame = 1'b1;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign Done_o = (state_reg == ST_DONE);
    assign Busy_o = (state_reg != ST_IDLE);

    // ------------------------------------------------------------------
    // State, counters and output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg    <= ST_IDLE;
            line_cnt_reg <= '0;
            hreg_reg     <= '0;
            wr_addr_reg  <= '0;
            OutRamWe_o   <= 1'b0;
            OutRamAddr_o <= '0;
            OutRamData_o <= '0;
        end else begin
            state_reg  <= state_next;
            OutRamWe_o <= issue_wr;

            if (abort) begin
                line_cnt_reg <= '0;
                hreg_reg     <= '0;
            end else if (vld_d) begin
                if (!col_d[0]) begin
                    hreg_reg <= q;
                end
                if (col_d == COL_LAST) begin
                    line_cnt_reg <= (line_cnt_reg == LINE_LAST) ? '0 : line_cnt_reg + 1'b1;
                end
            end

            // A frame start is always on an even line, so it never
            // coincides with a write.
            if (start_frame) begin
                wr_addr_reg <= '0;
            end else if (issue_wr) begin
                OutRamAddr_o <= wr_addr_reg;
                OutRamData_o <= p_max;
                wr_addr_reg  <= (wr_addr_reg == ADDR_LAST) ? '0 : wr_addr_reg + 1'b1;
            end
        end
    end

    // Line buffer holds even-line horizontal maxima; always written before
    // it is read within a frame, so it needs no reset.
    always_ff @(posedge clk) begin
        if (lb_wr) begin
            linebuf[col_idx] <= h_max;
        end
    end

endmodule

// File: tb/tb_l1_conv_out_ctrl.sv
// Self-checking bench for l1_conv_out_ctrl: drives whole frames of MAC
// results and compares the pooled write stream against a frame-level model.
module tb_l1_conv_out_ctrl;

    localparam int WN = 24;
    localparam int LN = 50;
    localparam int NS = WN * LN;
    localparam int NW = (LN / 2) * (WN / 2);

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              vbit_i = 1'b0;
    logic [4:0]        ConvWinCnt_i = '0;
    logic signed [19:0] ConvResult_i = '0;
    logic              OutRamWe_o;
    logic [8:0]        OutRamAddr_o;
    logic [7:0]        OutRamData_o;
    logic              Done_o;
    logic              Busy_o;

    always #5 clk = ~clk;

    l1_conv_out_ctrl dut (
        .clk          (clk),
        .rstn         (rstn),
        .vbit_i       (vbit_i),
        .ConvWinCnt_i (ConvWinCnt_i),
        .ConvResult_i (ConvResult_i),
        .OutRamWe_o   (OutRamWe_o),
        .OutRamAddr_o (OutRamAddr_o),
        .OutRamData_o (OutRamData_o),
        .Done_o       (Done_o),
        .Busy_o       (Busy_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Cycle counter and output monitor.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int wr_addr_q[$];
    int wr_data_q[$];
    int wr_cyc_q[$];
    int done_q[$];
    bit busy_hist [65536];

    always @(negedge clk) begin
        if (OutRamWe_o) begin
            wr_addr_q.push_back(int'(OutRamAddr_o));
            wr_data_q.push_back(int'(OutRamData_o));
            wr_cyc_q.push_back(cyc);
            $display("wr  cyc=%0d addr=%0d data=%0d", cyc, OutRamAddr_o, OutRamData_o);
        end
        if (Done_o) done_q.push_back(cyc);
        if (cyc < 65536) busy_hist[cyc] = Busy_o;
    end

    // Reference model: frame of MAC results -> pooled output words.
    int res_mem [NS];
    int exp_mem [NW];

    function automatic int quant(input int r);
        if (r < 0) return 0;
        if (r / 64 > 127) return 127;
        return r / 64;
    endfunction

    task automatic build_expected();
        for (int a = 0; a < NW; a++) begin
            int best;
            best = 0;
            for (int dl = 0; dl < 2; dl++) begin
                for (int dw = 0; dw < 2; dw++) begin
                    int v;
                    v = quant(res_mem[(2 * (a / 12) + dl) * WN + 2 * (a % 12) + dw]);
                    if (v > best) best = v;
                end
            end
            exp_mem[a] = best;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        vbit_i = 1'b0;
        ConvResult_i = '0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_mon();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        done_q.delete();
    endtask

    // Drives n samples of res_mem; result k is presented two cycles after
    // its window index. rst_at >= 0 pulls reset mid-frame at that sample.
    task automatic drive_frame(input int n, input int rst_at, output int s);
        s = cyc;
        for (int j = 0; j < n + 2; j++) begin
            if (j == 0) s = cyc;
            vbit_i       = (j < n);
            ConvWinCnt_i = (j < n) ? 5'(j % WN) : 5'(n % WN);
            ConvResult_i = (j >= 2) ? 20'(res_mem[j - 2]) : 20'sd0;
            if (j == rst_at) begin
                #3;
                rstn = 1'b0;
                #1;
                check("rst_mid_we",   32'(OutRamWe_o),   0);
                check("rst_mid_addr", 32'(OutRamAddr_o), 0);
                check("rst_mid_data", 32'(OutRamData_o), 0);
                check("rst_mid_done", 32'(Done_o),       0);
                check("rst_mid_busy", 32'(Busy_o),       0);
                idle(3);
                rstn = 1'b1;
                return;
            end
            tick();
        end
        ConvResult_i = '0;
    endtask

    task automatic run_full(input string tag);
        int s;
        clear_mon();
        build_expected();
        drive_frame(NS, -1, s);
        idle(8);
        check({tag, "_nwr"}, wr_addr_q.size(), NW);
        for (int i = 0; i < wr_addr_q.size() && i < NW; i++) begin
            check($sformatf("%s_addr%0d", tag, i), wr_addr_q[i], i);
            check($sformatf("%s_data%0d", tag, i), wr_data_q[i], exp_mem[i]);
        end
        if (wr_cyc_q.size() > 0) begin
            check({tag, "_first_lat"}, wr_cyc_q[0], s + WN + 4);
            check({tag, "_last_lat"}, wr_cyc_q[wr_cyc_q.size() - 1], s + NS + 2);
        end
        check({tag, "_ndone"}, done_q.size(), 1);
        if (done_q.size() > 0) check({tag, "_done_cyc"}, done_q[0], s + NS + 3);
        check({tag, "_busy_pre"},  32'(busy_hist[s + 2]), 0);
        check({tag, "_busy_on"},   32'(busy_hist[s + 3]), 1);
        check({tag, "_busy_done"}, 32'(busy_hist[s + NS + 3]), 1);
        check({tag, "_busy_off"},  32'(busy_hist[s + NS + 4]), 0);
        $display("frame %s: %0d writes, %0d done pulses", tag, wr_addr_q.size(), done_q.size());
    endtask

    task automatic fill_random(input int lo, input int span);
        for (int k = 0; k < NS; k++) res_mem[k] = int'($urandom_range(0, span)) + lo;
    endtask

    initial begin
        int s;

        // Reset state
        idle(3);
        check("rst_we",   32'(OutRamWe_o),   0);
        check("rst_addr", 32'(OutRamAddr_o), 0);
        check("rst_data", 32'(OutRamData_o), 0);
        check("rst_done", 32'(Done_o),       0);
        check("rst_busy", 32'(Busy_o),       0);
        rstn = 1'b1;
        idle(4);

        // Ramp: window*64 + line
        for (int k = 0; k < NS; k++) res_mem[k] = (k % WN) * 64 + k / WN;
        run_full("ramp");

        // All negative -> ReLU zero
        for (int k = 0; k < NS; k++) res_mem[k] = -1000;
        run_full("neg");

        // All large -> saturated
        for (int k = 0; k < NS; k++) res_mem[k] = 524287;
        run_full("sat");

        // Single non-zero sample at line 3, col 5
        for (int k = 0; k < NS; k++) res_mem[k] = 0;
        res_mem[3 * WN + 5] = 640;
        run_full("pool");
        check("pool_model14", exp_mem[14], 10);

        // Abort at line 10 col 7
        fill_random(-4000, 24000);
        build_expected();
        clear_mon();
        drive_frame(10 * WN + 7, -1, s);
        idle(8);
        check("abort_nwr", wr_addr_q.size(), 60);
        for (int i = 0; i < wr_addr_q.size() && i < 60; i++) begin
            check($sformatf("abort_addr%0d", i), wr_addr_q[i], i);
            check($sformatf("abort_data%0d", i), wr_data_q[i], exp_mem[i]);
        end
        if (wr_cyc_q.size() > 0)
            check("abort_last_wr", wr_cyc_q[wr_cyc_q.size() - 1], s + 10 * WN + 2);
        check("abort_ndone", done_q.size(), 0);
        check("abort_busy_hold", 32'(busy_hist[s + 10 * WN + 9]), 1);
        check("abort_busy_fall", 32'(busy_hist[s + 10 * WN + 10]), 0);
        $display("frame abort: %0d writes, %0d done pulses", wr_addr_q.size(), done_q.size());

        fill_random(-4000, 24000);
        run_full("after_abort");

        // Reset mid-frame, then a clean frame
        fill_random(-4000, 24000);
        drive_frame(NS, 600, s);
        idle(5);
        fill_random(-524288, 1048575);
        run_full("after_reset");

        fill_random(-2000, 12000);
        run_full("rnd");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/l1_conv_out_ctrl.md
# l1_conv_out_ctrl

Layer-1 convolution output stage, directly downstream of the L1 input controller and the layer-1 MAC array. Captures one MAC result per conv window while the input controller's valid bit is high, applies ReLU, requantisation and 2x2 max-pooling, and writes pooled int8 results sequentially into the layer-1 output RAM. For a 50-line x 24-window frame it produces 25 x 12 = 300 output words and pulses a done flag.

## Interface
- ACC_W, 20, signed MAC result width
- OUT_W, 8, output word width (signed container, non-negative values)
- SHIFT, 6, arithmetic right shift applied before saturation
- PIPE_LAT, 2, cycles from window count presented to its MAC result valid
- WIN_NUM, 24, windows per line (even)
- LINE_NUM, 50, lines per frame (even)
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- vbit_i  in  1  work-active from input controller
- ConvWinCnt_i  in  5  window index 0..WIN_NUM-1 from input controller
- ConvResult_i  in  ACC_W  signed MAC result, valid PIPE_LAT cycles after its window index
- OutRamWe_o  out  1  output RAM write strobe
- OutRamAddr_o  out  9  output RAM address 0..299
- OutRamData_o  out  OUT_W  pooled result
- Done_o  out  1  one-cycle pulse after last write
- Busy_o  out  1  frame in progress

## Operation
- Delay line: vbit_i and ConvWinCnt_i delayed PIPE_LAT cycles -> vld_d, col_d. Sample captured in any cycle with vld_d=1.
- Quantise: q = (r<0) ? 0 : min(r >>> SHIFT, 2^(OUT_W-1)-1).
- Horizontal pool: even col_d stores q in hreg; odd col_d forms h = max(hreg, q).
- Vertical pool: line counter line_cnt 0..LINE_NUM-1 increments on capture with col_d==WIN_NUM-1, wraps to 0. Even line: h written to line buffer entry col_d>>1 (WIN_NUM/2 entries). Odd line: p = max(linebuf[col_d>>1], h), registered to output with write strobe.
- Write address counter wr_addr increments after each write; 0..(LINE_NUM/2)*(WIN_NUM/2)-1.
- FSM: IDLE -> RUN on vld_d=1 (Busy_o=1); RUN -> DONE when write at wr_addr=299 issued; DONE -> IDLE after one cycle (Done_o=1 in DONE). RUN -> IDLE (abort) if vld_d falls while line_cnt!=0 or col_d!=0 mid-frame: counters and hreg cleared, no Done_o, any pending write in output register still completes.
- vld_d high in DONE/IDLE with line_cnt=0 starts a new frame; wr_addr reset to 0 on IDLE->RUN.
- ConvWinCnt_i outside 0..WIN_NUM-1 with vbit_i=1 is illegal; no required behaviour.

## Timing
- Reset: OutRamWe_o=0, OutRamAddr_o=0, OutRamData_o=0, Done_o=0, Busy_o=0, state IDLE, all counters 0.
- Write latency: OutRamWe_o asserts exactly 1 cycle after capture of odd-line odd-column sample; data/address registered with it.
- Frame latency: first write 1 cycle after capture of line 1, col 1 sample.
- Done_o: 1 cycle after final write strobe (addr 299); single cycle.
- Busy_o high from first capture cycle+1 through the DONE cycle.
- Abort takes effect the cycle after vld_d falls.

## Structure
- Shared package l1_conv_pkg: WIN_NUM, LINE_NUM, OUT_W, state typedef (IDLE/RUN/DONE), quantise saturation constant.
- Sub-module l1_relu_quant (combinational ReLU + shift + saturate), reused by later layers; delay line and line buffer inline.

## Test plan
- Full frame, ConvResult_i = window*64 + line: 300 writes, addr 0..299 in order, data = min(((2*(a%12)+1)*64 + 2*(a/12)+1)>>6, 127), Done_o one pulse after addr 299.
- Negative results (all -1000): all 300 writes data 0.
- Large results (all 2^19-1): all data 127 (saturated).
- Pool ordering: only line 3, col 5 = 640, all else 0: addr 14 data 10, all other addresses 0.
- Abort: vbit_i drops at line 10 col 7: no further writes after pending one, Done_o stays 0, Busy_o falls; next full frame restarts at addr 0.
- Reset asserted mid-frame: all outputs 0 asynchronously; after release, new frame completes normally with 300 writes.
